// File: rtl/program_loader.sv
// program_loader: receives a program as a byte stream, assembles big-endian
// 32-bit words, writes them into instruction memory and holds the CPU in
// reset until the whole program is loaded.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing mod-256 checksum byte).
//
// state | meaning
// IDLE  | after reset, waiting for load_start
// RECV  | accepting payload bytes, byte_ready high
// WRITE | one-cycle memory write of the assembled word
// CHECK | accepting the checksum byte (LOADER_CHECKSUM_EN only)
// DONE  | load complete, CPU released from reset
// ERROR | load rejected or checksum bad, CPU held in reset
module program_loader #(
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = ADDR_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [LEN_WIDTH-1:0]  load_len,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int WIDX_W = ADDR_WIDTH - 2;
  localparam logic [LEN_WIDTH:0] CAPACITY = (LEN_WIDTH + 1)'(1) << WIDX_W;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE, ERROR} state_t;
`else
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;
`endif

  state_t                 state, state_d;
  logic [1:0]             byte_cnt;
  logic [LEN_WIDTH-1:0]   word_idx;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [23:0]            shreg;
  logic                   start_ok;
  logic                   last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             sum;
`endif

  assign start_ok  = load_start && (state == IDLE || state == DONE || state == ERROR);
  assign last_word = (word_idx + LEN_WIDTH'(1)) == len_q;

  // Next-state logic; byte_ready is high exactly in RECV/CHECK, so byte_valid
  // alone qualifies acceptance there.
  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (load_start) begin
          if (load_len == '0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
`endif
          end else if ({1'b0, load_len} > CAPACITY) begin
            state_d = ERROR;
          end else begin
            state_d = RECV;
          end
        end
      end
      RECV: begin
        if (byte_valid && byte_cnt == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (byte_valid) state_d = (byte_in == sum) ? DONE : ERROR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      word_idx   <= '0;
      len_q      <= '0;
      shreg      <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      state      <= state_d;
`ifdef LOADER_CHECKSUM_EN
      byte_ready <= (state_d == RECV) || (state_d == CHECK);
`else
      byte_ready <= (state_d == RECV);
`endif
      mem_we     <= (state_d == WRITE);
      busy       <= (state_d == RECV) || (state_d == WRITE);
      done       <= (state_d == DONE);
      error      <= (state_d == ERROR);
      cpu_reset  <= (state_d != DONE);

      if (start_ok) begin
        byte_cnt <= '0;
        word_idx <= '0;
        len_q    <= load_len;
`ifdef LOADER_CHECKSUM_EN
        sum      <= '0;
`endif
      end

      if (state == RECV && byte_valid) begin
        shreg    <= {shreg[15:0], byte_in};
        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        sum      <= sum + byte_in;
`endif
      end

      // The fourth byte is still on byte_in when the write is launched.
      if (state == RECV && state_d == WRITE) begin
        mem_addr  <= {word_idx[WIDX_W-1:0], 2'b00};
        mem_wdata <= {shreg, byte_in};
      end

      if (state == WRITE) word_idx <= word_idx + LEN_WIDTH'(1);
    end
  end

endmodule
